btb_fa: RTL and testbench
=========================

// Module: btb_fa
// PURPOSE
//  Fully-associative branch target buffer in IF. Looks up fetch PC, returns registered
//  hit/taken/target one cycle later. Trains from EX branch resolution.
//  Drives the replacement-policy request side (replace_en/fresh_en/fresh_line_index)
//  and consumes the policy's victim index.
// PARAMETERS
//  IDX_WIDTH  4   line index width
//  LINE_NUM   16  number of lines; must equal 2**IDX_WIDTH
// PORTS
//  clk               in   1          clock
//  reset             in   1          synchronous, active-high
//  if_stall          in   1          IF stalled: hold pred_* outputs
//  lookup_pc         in   32         fetch PC; tag = lookup_pc[31:2]
//  pred_hit          out  1          registered: lookup_pc matched a valid line
//  pred_taken        out  1          registered: hit & counter[1]
//  pred_target       out  32         registered: target of hit line, else 0
//  pred_index        out  IDX_WIDTH  registered: hit line index, else 0
//  id_hit            in   1          instruction in ID was a BTB hit
//  id_index          in   IDX_WIDTH  pred_index carried to ID
//  id_stall          in   1          ID stalled
//  upd_valid         in   1          EX resolved a branch/jump this cycle
//  upd_pc            in   32         resolved branch PC
//  upd_taken         in   1          actual direction
//  upd_target        in   32         actual target
//  victim_index      in   IDX_WIDTH  policy's current victim line
//  replace_en        out  1          policy: victim_index was overwritten
//  fresh_en          out  1          policy: fresh_line_index was used
//  fresh_line_index  out  IDX_WIDTH  line to mark recently used
// BEHAVIOUR
//  State: valid[LINE_NUM], tag[30], target[32], ctr[2] per line. Reset: all valid=0.
//   tag/target/ctr need no reset. All pred_* = 0 after reset.
//  Lookup: compare lookup_pc[31:2] with every valid tag; register result on clk when
//   !if_stall; hold when if_stall. Latency 1. Read-before-write: same-cycle update
//   is not visible to that lookup.
//  Update (upd_valid), independent CAM search on upd_pc[31:2] at update time:
//   hit line h: ctr saturating +1 if taken, -1 if not (sat 3/0);
//    target[h] <= upd_target if taken.
//   miss & taken: allocate. Lowest-index invalid line if any; else victim_index.
//    Write valid=1, tag, target, ctr=2'b10.
//   miss & !taken: no state change.
//  Policy outputs (combinational, same cycle as the condition):
//   P1 allocate into victim (no invalid line): replace_en=1, fresh_en=0.
//   P2 allocate into invalid line k: fresh_en=1, fresh_line_index=k, replace_en=0.
//   P3 else id_hit & !id_stall: fresh_en=1, fresh_line_index=id_index.
//   P4 else replace_en=0, fresh_en=0, fresh_line_index=0.
//   Priority P1>P2>P3; lower-priority fresh in the same cycle is dropped, not queued.
//   Update hits produce no policy request.
//  Uniqueness: re-search on update guarantees at most one line per tag.
//   Back-to-back updates of same new PC allocate once, then hit.
//  reset mid-operation: all lines invalidated, pred_* cleared next edge; policy
//   outputs 0 while reset is high.
// TESTING
//  T1 reset; lookup 0x400 -> next cycle pred_hit=0, pred_target=0, replace_en=fresh_en=0.
//  T2 upd 0x400 taken ->0x800 -> fresh_en=1, idx=0. Lookup 0x400 -> hit, taken,
//     target 0x800, pred_index=0.
//  T3 allocate 16 distinct taken PCs -> idx 0..15 via fresh_en. 17th with victim_index=5
//     -> replace_en=1; line 5 holds new PC; old line-5 PC misses.
//  T4 upd 0x400 not-taken twice from ctr=2 -> ctr=0, pred_taken=0, pred_hit=1;
//     3 more taken -> ctr=3 (saturates).
//  T5 same cycle: full-BTB allocate + id_hit idx=3 -> replace_en=1, fresh_en=0.
//     With id_stall=1 and no allocate -> both 0.
//  T6 if_stall=1 while lookup_pc changes -> pred_* held; update then lookup same PC
//     same cycle -> old (miss) result.

Source files
------------

// File: rtl/btb_fa_if.sv
// btb_fa_if: signal bundle between the fully-associative BTB and its
// surroundings (IF lookup, ID feedback, EX update, replacement policy).
//   slave  : BTB side (drives pred_* and policy requests)
//   master : pipeline/policy side (drives lookup, ID, update, victim)
interface btb_fa_if #(
    parameter int IDX_WIDTH = 4
);
    logic                 if_stall;
    logic [31:0]          lookup_pc;
    logic                 pred_hit;
    logic                 pred_taken;
    logic [31:0]          pred_target;
    logic [IDX_WIDTH-1:0] pred_index;
    logic                 id_hit;
    logic [IDX_WIDTH-1:0] id_index;
    logic                 id_stall;
    logic                 upd_valid;
    logic [31:0]          upd_pc;
    logic                 upd_taken;
    logic [31:0]          upd_target;
    logic [IDX_WIDTH-1:0] victim_index;
    logic                 replace_en;
    logic                 fresh_en;
    logic [IDX_WIDTH-1:0] fresh_line_index;

    modport slave (
        input  if_stall, lookup_pc, id_hit, id_index, id_stall,
               upd_valid, upd_pc, upd_taken, upd_target, victim_index,
        output pred_hit, pred_taken, pred_target, pred_index,
               replace_en, fresh_en, fresh_line_index
    );

    modport master (
        output if_stall, lookup_pc, id_hit, id_index, id_stall,
               upd_valid, upd_pc, upd_taken, upd_target, victim_index,
        input  pred_hit, pred_taken, pred_target, pred_index,
               replace_en, fresh_en, fresh_line_index
    );
endinterface

// File: rtl/btb_fa.sv
// btb_fa: fully-associative branch target buffer for the IF stage.
// Ports:
//   clk   - clock
//   reset - synchronous, active-high; invalidates all lines, clears pred_*
//   bus   - btb_fa_if.slave: lookup_pc -> registered pred_{hit,taken,target,index};
//           EX update (upd_*) trains lines; replace_en/fresh_en/fresh_line_index
//           drive the replacement policy, victim_index comes back from it.
module btb_fa #(
    parameter int IDX_WIDTH = 4,
    parameter int LINE_NUM  = 16
) (
    input  logic     clk,
    input  logic     reset,
    btb_fa_if.slave  bus
);
    localparam int unsigned N = LINE_NUM;

    logic [N-1:0]         valid_q, valid_d;
    logic [29:0]          tag_q    [N];
    logic [29:0]          tag_d    [N];
    logic [31:0]          target_q [N];
    logic [31:0]          target_d [N];
    logic [1:0]           ctr_q    [N];
    logic [1:0]           ctr_d    [N];

    logic                 pred_hit_q, pred_hit_d;
    logic                 pred_taken_q, pred_taken_d;
    logic [31:0]          pred_target_q, pred_target_d;
    logic [IDX_WIDTH-1:0] pred_index_q, pred_index_d;

    logic                 lk_hit, upd_hit, free_found, alloc;
    logic [IDX_WIDTH-1:0] lk_idx, upd_idx, free_idx, wr_idx;
    logic                 unused_pc_bits;

    // Word-aligned PCs: the low two bits never take part in matching.
    assign unused_pc_bits = ^{bus.lookup_pc[1:0], bus.upd_pc[1:0]};

    // Two independent CAM searches plus the lowest free line.
    always_comb begin
        lk_hit     = 1'b0;
        lk_idx     = '0;
        upd_hit    = 1'b0;
        upd_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (valid_q[i] && tag_q[i] == bus.lookup_pc[31:2]) begin
                lk_hit = 1'b1;
                lk_idx = i[IDX_WIDTH-1:0];
            end
            if (valid_q[i] && tag_q[i] == bus.upd_pc[31:2]) begin
                upd_hit = 1'b1;
                upd_idx = i[IDX_WIDTH-1:0];
            end
            if (!valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = i[IDX_WIDTH-1:0];
            end
        end
    end

    assign alloc  = !reset && bus.upd_valid && !upd_hit && bus.upd_taken;
    assign wr_idx = free_found ? free_idx : bus.victim_index;

    // Line state update: hit training or allocation.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (reset) begin
            valid_d = '0;
        end else if (bus.upd_valid && upd_hit) begin
            if (bus.upd_taken) begin
                ctr_d[upd_idx]    = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'd1;
                target_d[upd_idx] = bus.upd_target;
            end else begin
                ctr_d[upd_idx]    = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'd1;
            end
        end else if (alloc) begin
            valid_d[wr_idx]  = 1'b1;
            tag_d[wr_idx]    = bus.upd_pc[31:2];
            target_d[wr_idx] = bus.upd_target;
            ctr_d[wr_idx]    = 2'b10;
        end
    end

    // Policy requests; allocation outranks the ID-stage touch, which is dropped.
    always_comb begin
        bus.replace_en       = 1'b0;
        bus.fresh_en         = 1'b0;
        bus.fresh_line_index = '0;
        if (!reset) begin
            if (alloc && !free_found) begin
                bus.replace_en = 1'b1;
            end else if (alloc) begin
                bus.fresh_en         = 1'b1;
                bus.fresh_line_index = free_idx;
            end else if (bus.id_hit && !bus.id_stall) begin
                bus.fresh_en         = 1'b1;
                bus.fresh_line_index = bus.id_index;
            end
        end
    end

    // Registered prediction, held while IF is stalled.
    always_comb begin
        pred_hit_d    = pred_hit_q;
        pred_taken_d  = pred_taken_q;
        pred_target_d = pred_target_q;
        pred_index_d  = pred_index_q;
        if (reset) begin
            pred_hit_d    = 1'b0;
            pred_taken_d  = 1'b0;
            pred_target_d = '0;
            pred_index_d  = '0;
        end else if (!bus.if_stall) begin
            pred_hit_d    = lk_hit;
            pred_taken_d  = lk_hit && ctr_q[lk_idx][1];
            pred_target_d = lk_hit ? target_q[lk_idx] : '0;
            pred_index_d  = lk_idx;
        end
    end

    always_ff @(posedge clk) begin
        valid_q       <= valid_d;
        tag_q         <= tag_d;
        target_q      <= target_d;
        ctr_q         <= ctr_d;
        pred_hit_q    <= pred_hit_d;
        pred_taken_q  <= pred_taken_d;
        pred_target_q <= pred_target_d;
        pred_index_q  <= pred_index_d;
    end

    assign bus.pred_hit    = pred_hit_q;
    assign bus.pred_taken  = pred_taken_q;
    assign bus.pred_target = pred_target_q;
    assign bus.pred_index  = pred_index_q;
endmodule

// File: tb/tb_btb_fa.sv
module tb_btb_fa;
    typedef struct {
        logic        hit;
        logic        taken;
        logic [31:0] tgt;
        logic [3:0]  idx;
    } pred_t;

    typedef struct {
        logic       rep;
        logic       fresh;
        logic [3:0] fli;
        logic       chk_fli;
    } pol_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    btb_fa_if #(.IDX_WIDTH(4)) bus ();
    btb_fa #(.IDX_WIDTH(4), .LINE_NUM(16)) dut (.clk(clk), .reset(reset), .bus(bus));

    pred_t pred_exp[$];
    pol_t  pol_exp[$];
    logic  lk_req   = 1'b0;
    logic  pol_chk  = 1'b0;
    logic  pred_due = 1'b0;
    int    checks   = 0;
    int    errors   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // A lookup issued in one cycle presents its prediction after the next edge.
    always @(posedge clk) pred_due <= lk_req;

    always @(negedge clk) begin
        if (pol_chk) begin
            if (pol_exp.size() == 0) begin
                checks++; errors++;
                $display("FAIL pol_queue: got empty expected entry");
            end else begin
                pol_t p;
                p = pol_exp.pop_front();
                chk("replace_en", bus.replace_en, p.rep);
                chk("fresh_en", bus.fresh_en, p.fresh);
                if (p.chk_fli) chk("fresh_line_index", bus.fresh_line_index, p.fli);
            end
        end
        if (pred_due) begin
            if (pred_exp.size() == 0) begin
                checks++; errors++;
                $display("FAIL pred_queue: got empty expected entry");
            end else begin
                pred_t e;
                e = pred_exp.pop_front();
                chk("pred_hit", bus.pred_hit, e.hit);
                chk("pred_taken", bus.pred_taken, e.taken);
                chk("pred_target", bus.pred_target, e.tgt);
                chk("pred_index", bus.pred_index, e.idx);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        lk_req           = 1'b0;
        pol_chk          = 1'b0;
        bus.upd_valid    = 1'b0;
        bus.id_hit       = 1'b0;
        bus.id_stall     = 1'b0;
        bus.if_stall     = 1'b0;
        bus.victim_index = '0;
        bus.id_index     = '0;
    endtask

    task automatic look(input logic [31:0] pc, input logic h, input logic t,
                        input logic [31:0] tgt, input logic [3:0] idx);
        bus.lookup_pc = pc;
        lk_req = 1'b1;
        pred_exp.push_back('{hit: h, taken: t, tgt: tgt, idx: idx});
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = pc;
        bus.upd_taken  = tk;
        bus.upd_target = tgt;
    endtask

    task automatic pol(input logic rep, input logic fr, input logic [3:0] fli, input logic cf);
        pol_chk = 1'b1;
        pol_exp.push_back('{rep: rep, fresh: fr, fli: fli, chk_fli: cf});
    endtask

    initial begin
        reset = 1'b1;
        bus.if_stall = 1'b0; bus.lookup_pc = '0; bus.id_hit = 1'b0; bus.id_index = '0;
        bus.id_stall = 1'b0; bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_taken = 1'b0;
        bus.upd_target = '0; bus.victim_index = '0;
        step();
        // Reset: policy quiet despite activity, prediction cleared.
        upd(32'h400, 1, 32'h800); bus.id_hit = 1'b1; bus.id_index = 4'd3;
        pol(0, 0, 0, 1); look(32'h400, 0, 0, 0, 0); step();
        reset = 1'b0;
        // T1
        look(32'h400, 0, 0, 0, 0); step();
        // T2
        upd(32'h400, 1, 32'h800); pol(0, 1, 0, 1); step();
        look(32'h400, 1, 1, 32'h800, 0); step();
        // T3: fill remaining lines, then replace victim 5
        for (int i = 1; i < 16; i++) begin
            upd(32'h1000 + 32'(4 * i), 1, 32'h1100 + 32'(4 * i));
            pol(0, 1, 4'(i), 1); step();
        end
        bus.victim_index = 4'd5; upd(32'h2000, 1, 32'h2100); pol(1, 0, 0, 0); step();
        look(32'h2000, 1, 1, 32'h2100, 5); step();
        look(32'h1014, 0, 0, 0, 0); step();
        look(32'h1018, 1, 1, 32'h1118, 6); step();
        // T4: counter saturation at both ends, line 0
        for (int i = 0; i < 3; i++) begin
            upd(32'h400, 0, 32'hdead); pol(0, 0, 0, 1); step();
        end
        look(32'h400, 1, 0, 32'h800, 0); step();
        upd(32'h400, 1, 32'h900); step();
        look(32'h400, 1, 0, 32'h900, 0); step();
        upd(32'h400, 1, 32'h900); step();
        look(32'h400, 1, 1, 32'h900, 0); step();
        for (int i = 0; i < 3; i++) begin
            upd(32'h400, 1, 32'h900); step();
        end
        look(32'h400, 1, 1, 32'h900, 0); step();
        upd(32'h400, 0, 32'h0); step();
        look(32'h400, 1, 1, 32'h900, 0); step();
        upd(32'h400, 0, 32'h0); step();
        look(32'h400, 1, 0, 32'h900, 0); step();
        // T5: allocate outranks ID touch; back-to-back same PC allocates once
        bus.victim_index = 4'd9; upd(32'h3000, 1, 32'h3100);
        bus.id_hit = 1'b1; bus.id_index = 4'd3; pol(1, 0, 0, 0); step();
        bus.victim_index = 4'd4; upd(32'h3000, 1, 32'h3200); pol(0, 0, 0, 1); step();
        look(32'h3000, 1, 1, 32'h3200, 9); step();
        look(32'h1024, 0, 0, 0, 0); step();
        look(32'h1010, 1, 1, 32'h1110, 4); step();
        bus.id_hit = 1'b1; bus.id_index = 4'd3; bus.id_stall = 1'b1; pol(0, 0, 0, 1); step();
        bus.id_hit = 1'b1; bus.id_index = 4'd3; pol(0, 1, 3, 1); step();
        upd(32'h400, 1, 32'h900); bus.id_hit = 1'b1; bus.id_index = 4'd6; pol(0, 1, 6, 1); step();
        // T6: stall holds; same-cycle update is invisible to lookup
        look(32'h3000, 1, 1, 32'h3200, 9); step();
        look(32'h400, 1, 1, 32'h3200, 9); bus.if_stall = 1'b1; step();
        look(32'h1018, 1, 1, 32'h3200, 9); bus.if_stall = 1'b1; step();
        bus.victim_index = 4'd2; upd(32'h4000, 1, 32'h4100); pol(1, 0, 0, 0);
        look(32'h4000, 0, 0, 0, 0); step();
        look(32'h4000, 1, 1, 32'h4100, 2); step();
        // Mid-operation reset
        reset = 1'b1;
        look(32'h4000, 0, 0, 0, 0); bus.if_stall = 1'b1;
        upd(32'h5000, 1, 32'h5100); pol(0, 0, 0, 1); step();
        reset = 1'b0;
        look(32'h4000, 0, 0, 0, 0); step();
        look(32'h400, 0, 0, 0, 0); step();
        upd(32'h5000, 1, 32'h5100); bus.id_hit = 1'b1; bus.id_index = 4'd7; pol(0, 1, 0, 1); step();
        upd(32'h6000, 1, 32'h6100); pol(0, 1, 1, 1); step();
        look(32'h5000, 1, 1, 32'h5100, 0); step();
        look(32'h6000, 1, 1, 32'h6100, 1); step();
        step(); step();
        if (pred_exp.size() != 0 || pol_exp.size() != 0) begin
            checks++; errors++;
            $display("FAIL queue_drain: got %0d/%0d left expected 0/0", pred_exp.size(), pol_exp.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
